// File: rtl/out_fm_store_filter_pkg.sv
// Shared definitions for the out_fm store filter.
// Holds the default tile dimensions, the FSM state encoding and the
// element-count helper used to size the per-tile pop budget.
package out_fm_store_filter_pkg;

  localparam int TM_DEF = 16;
  localparam int TR_DEF = 64;
  localparam int TC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of elements in one tile (every one of them is popped).
  function automatic int elem_count(input int tm, input int tr, input int tc);
    return tm * tr * tc;
  endfunction

endpackage

// File: rtl/out_fm_store_filter_nest3_counter.sv
// Three-level nested tile counter: tc innermost, then tr, then tm.
// Ports:
//   clk, rst   clock, async active-high reset
//   ena        advance by one element
//   clean      synchronous clear to (0,0,0)
//   tc/tr/tm   current coordinates inside the tile
//   done       coordinates are at the last element of the tile
module out_fm_store_filter_nest3_counter #(
  parameter int CW  = 16,
  parameter int N_C = 16,
  parameter int N_R = 64,
  parameter int N_M = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clean,
  output logic [CW-1:0] tc,
  output logic [CW-1:0] tr,
  output logic [CW-1:0] tm,
  output logic          done
);

  logic tc_w, tr_w, tm_w;

  assign tc_w = (tc == CW'(N_C - 1));
  assign tr_w = (tr == CW'(N_R - 1));
  assign tm_w = (tm == CW'(N_M - 1));
  assign done = tc_w && tr_w && tm_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc <= '0;
      tr <= '0;
      tm <= '0;
    end else if (clean) begin
      tc <= '0;
      tr <= '0;
      tm <= '0;
    end else if (ena) begin
      if (!tc_w) begin
        tc <= tc + 1'b1;
      end else begin
        tc <= '0;
        if (!tr_w) begin
          tr <= tr + 1'b1;
        end else begin
          tr <= '0;
          tm <= tm_w ? '0 : tm + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/out_fm_store_filter.sv
// Store-path tile filter: pops one Tm x Tr x Tc out_fm tile from the tile
// FIFO, computes the linear word address of each element in the full
// M x R x C array, writes the in-bounds elements and drops the padding.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    one-cycle pulse, begin a tile (IDLE only)
//   tile_base_m/r/c          tile origin, sampled on start
//   fifo_empty, fifo_pop     tile FIFO handshake
//   data_from_fifo           FIFO data, valid the cycle after fifo_pop
//   wr_valid/ready/addr/data memory-write request
//   busy                     tile in progress
//   done                     one-cycle pulse after the last element leaves
module out_fm_store_filter
  import out_fm_store_filter_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int DW = 32,
  parameter int M  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tm = TM_DEF,
  parameter int Tr = TR_DEF,
  parameter int Tc = TC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] tile_base_m,
  input  logic [CW-1:0] tile_base_r,
  input  logic [CW-1:0] tile_base_c,
  input  logic          fifo_empty,
  output logic          fifo_pop,
  input  logic [DW-1:0] data_from_fifo,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  localparam int N_ELEM = elem_count(Tm, Tr, Tc);
  localparam int PW     = $clog2(N_ELEM + 1);

  state_t st, st_n;

  logic [CW-1:0] bm, br, bc;
  logic [PW-1:0] pops_left;
  logic [CW-1:0] tc, tr, tm;
  logic          cnt_last;
  logic          start_ok;

  // element popped last cycle, waiting for its FIFO data
  logic          inf_v, inf_legal;
  logic [AW-1:0] inf_addr;

  // 2-entry buffer
  logic [1:0]           b_legal;
  logic [1:0][AW-1:0]   b_addr;
  logic [1:0][DW-1:0]   b_data;
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           cnt;

  logic          head_legal, leave;
  logic [1:0]    occ_after;
  logic          legal_now;
  logic [AW-1:0] addr_now;

  assign start_ok = (st == IDLE) && start;

  out_fm_store_filter_nest3_counter #(
    .CW(CW), .N_C(Tc), .N_R(Tr), .N_M(Tm)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .ena  (fifo_pop),
    .clean(start_ok),
    .tc   (tc),
    .tr   (tr),
    .tm   (tm),
    .done (cnt_last)
  );

  assign legal_now = (bm + tm < CW'(M)) && (br + tr < CW'(R)) && (bc + tc < CW'(C));
  assign addr_now  = ((AW'(bm) + AW'(tm)) * AW'(R) + (AW'(br) + AW'(tr))) * AW'(C)
                   + (AW'(bc) + AW'(tc));

  assign head_legal = b_legal[rd_ptr];
  // head leaves this cycle: padding is dropped unconditionally,
  // a real write leaves on handshake
  assign leave      = (cnt != 2'd0) && (!head_legal || wr_ready);
  // slots still taken after this cycle's departure; counting the leaving
  // head as free is what allows one element per cycle
  assign occ_after  = {1'b0, inf_v} + cnt - {1'b0, leave};

  assign fifo_pop = (st == RUN) && !fifo_empty && (pops_left != '0)
                  && (cnt != 2'd2) && (occ_after < 2'd2);

  assign wr_valid = (cnt != 2'd0) && head_legal;
  assign wr_addr  = b_addr[rd_ptr];
  assign wr_data  = b_data[rd_ptr];
  assign busy     = (st == RUN) || (st == DRAIN);
  assign done     = (st == DONE);

  always_comb begin
    st_n = st;
    case (st)
      IDLE:  if (start) st_n = RUN;
      RUN:   if (fifo_pop && cnt_last) st_n = DRAIN;
      // leave one cycle early so done lands right after the last departure
      DRAIN: if (!inf_v && (cnt == 2'd0 || (cnt == 2'd1 && leave))) st_n = DONE;
      DONE:  st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      bm        <= '0;
      br        <= '0;
      bc        <= '0;
      pops_left <= '0;
      inf_v     <= 1'b0;
      inf_legal <= 1'b0;
      inf_addr  <= '0;
      b_legal   <= '0;
      b_addr    <= '0;
      b_data    <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      cnt       <= '0;
    end else begin
      st <= st_n;
      if (start_ok) begin
        bm        <= tile_base_m;
        br        <= tile_base_r;
        bc        <= tile_base_c;
        pops_left <= PW'(N_ELEM);
      end else if (fifo_pop) begin
        pops_left <= pops_left - 1'b1;
      end
      inf_v <= fifo_pop;
      if (fifo_pop) begin
        inf_legal <= legal_now;
        inf_addr  <= addr_now;
      end
      if (inf_v) begin
        b_legal[wr_ptr] <= inf_legal;
        b_addr[wr_ptr]  <= inf_addr;
        b_data[wr_ptr]  <= data_from_fifo;
        wr_ptr          <= ~wr_ptr;
      end
      if (leave) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, inf_v} - {1'b0, leave};
    end
  end

endmodule

// File: tb/tb_out_fm_store_filter.sv
// Scoreboard bench for out_fm_store_filter on a reduced array
// (M=3, R=6, C=24, tile 2x4x16) so every scenario runs a full tile.
module tb_out_fm_store_filter;

  localparam int AW = 32, CW = 16, DW = 32;
  localparam int M = 3, R = 6, C = 24, TM = 2, TR = 4, TC = 16;
  localparam logic [31:0] DBASE = 32'hD000_0000;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } exp_t;

  logic          clk = 0, rst = 1, start = 0;
  logic [CW-1:0] tile_base_m = 0, tile_base_r = 0, tile_base_c = 0;
  logic          fifo_empty = 0, fifo_pop, wr_valid, wr_ready = 1, busy, done;
  logic [DW-1:0] data_from_fifo = 0, wr_data;
  logic [AW-1:0] wr_addr;

  out_fm_store_filter #(
    .AW(AW), .CW(CW), .DW(DW), .M(M), .R(R), .C(C), .Tm(TM), .Tr(TR), .Tc(TC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .tile_base_m(tile_base_m), .tile_base_r(tile_base_r), .tile_base_c(tile_base_c),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .data_from_fifo(data_from_fifo),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0, failed = 0;
  exp_t exp_q[$];
  int   pop_cnt = 0, tile_pops = 0, wr_cnt = 0, done_cnt = 0;
  int   last_pop_cyc = 0, last_wr_cyc = 0;
  bit   last_legal = 0, bp_mode = 0, em_mode = 0;
  logic [AW-1:0] first_addr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO / sink model: data follows a pop by one cycle, ready/empty modes
  initial begin
    bit pop_s;
    forever begin
      @(negedge clk);
      pop_s = fifo_pop;
      if (pop_s) begin
        last_pop_cyc = cyc;
        tile_pops++;
      end
      @(posedge clk);
      #1;
      if (pop_s) begin
        data_from_fifo = DBASE + pop_cnt;
        pop_cnt++;
      end
      fifo_empty = em_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
      wr_ready   = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected writes and checks handshake rules
  initial begin
    bit stall_prev = 0;
    logic [AW-1:0] pa = 0;
    logic [DW-1:0] pd = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        continue;
      end
      if (fifo_pop) chk("pop_while_empty", fifo_empty, 0);
      if (stall_prev) begin
        chk("stall_valid", wr_valid, 1);
        chk("stall_addr", wr_addr, pa);
        chk("stall_data", wr_data, pd);
      end
      if (wr_valid && wr_ready) begin
        if (wr_cnt == 0) first_addr = wr_addr;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL extra_write: got addr %0h data %0h expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      stall_prev = wr_valid && !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, last_legal ? last_wr_cyc + 1 : last_pop_cyc + 3);
      end
    end
  end

  task automatic build_q(input int bm, input int br, input int bc);
    int k = 0;
    int db = pop_cnt;
    bit lg = 0;
    exp_q.delete();
    for (int m = 0; m < TM; m++)
      for (int r = 0; r < TR; r++)
        for (int c = 0; c < TC; c++) begin
          lg = (bm + m < M) && (br + r < R) && (bc + c < C);
          if (lg) exp_q.push_back({32'(((bm + m) * R + (br + r)) * C + (bc + c)),
                                   DBASE + 32'(db + k)});
          k++;
        end
    last_legal = lg;
  endtask

  task automatic pulse_start(input int bm, input int br, input int bc);
    @(posedge clk); #2;
    start = 1;
    tile_base_m = CW'(bm); tile_base_r = CW'(br); tile_base_c = CW'(bc);
    @(posedge clk); #2;
    start = 0;
    // bases are sampled on start only
    tile_base_m = 16'hBEEF; tile_base_r = 16'h1234; tile_base_c = 16'h7777;
  endtask

  task automatic run_tile(input string nm, input int bm, input int br, input int bc,
                          input bit bp, input bit em, input bit extra,
                          input int exp_wr, input int exp_first);
    int i;
    @(posedge clk); #2;
    bp_mode = bp; em_mode = em;
    build_q(bm, br, bc);
    wr_cnt = 0; done_cnt = 0; tile_pops = 0;
    pulse_start(bm, br, bc);
    if (extra) begin
      repeat (10) @(posedge clk);
      #2;
      chk({nm, "_busy_mid"}, busy, 1);
      start = 1; tile_base_m = 0; tile_base_r = 0; tile_base_c = 0;
      @(posedge clk); #2;
      start = 0;
    end
    for (i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: got no done expected done within 4000 cycles", nm);
    end
    repeat (4) @(posedge clk);
    #2;
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_writes"}, wr_cnt, exp_wr);
    chk({nm, "_first_addr"}, first_addr, exp_first);
    chk({nm, "_pops"}, tile_pops, 128);
    chk({nm, "_q_left"}, exp_q.size(), 0);
    chk({nm, "_busy_end"}, busy, 0);
    bp_mode = 0; em_mode = 0;
  endtask

  initial begin
    #1;
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_addr", wr_addr, 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;

    run_tile("interior", 0, 0, 0, 0, 0, 0, 128, 0);
    run_tile("edge_c",   0, 0, 16, 0, 0, 0, 64, 16);
    run_tile("backpres", 0, 0, 0, 1, 0, 0, 128, 0);
    run_tile("fifo_gap", 0, 2, 0, 0, 1, 0, 128, 48);
    run_tile("last_ill", 2, 4, 16, 0, 0, 1, 16, 400);

    // reset in the middle of a tile
    @(posedge clk); #2;
    build_q(0, 0, 0);
    wr_cnt = 0; done_cnt = 0;
    pulse_start(0, 0, 0);
    repeat (20) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mrst_fifo_pop", fifo_pop, 0);
    chk("mrst_wr_valid", wr_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_wr_data", wr_data, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_idle", busy, 0);

    run_tile("after_rst", 1, 2, 8, 0, 0, 0, 128, 200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
